// File: rtl/register_file_sb.sv
// Decode-stage register file: two async read ports, one sync write port and a pending-write
// scoreboard that drives operand stalls. Define RF_BYPASS_EN to forward same-cycle writeback.
module register_file_sb #(
  parameter int unsigned WORD_LEN = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   r1_add,
  input  logic [ADDR_W-1:0]   r2_add,
  output logic [WORD_LEN-1:0] r1,
  output logic [WORD_LEN-1:0] r2,
  input  logic                write_signal,
  input  logic [ADDR_W-1:0]   write_add,
  input  logic [WORD_LEN-1:0] write_data,
  input  logic                issue_signal,
  input  logic [ADDR_W-1:0]   issue_add,
  input  logic                r1_need,
  input  logic                r2_need,
  output logic                r1_busy,
  output logic                r2_busy,
  output logic                stall,
  output logic [ADDR_W:0]     pending_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [WORD_LEN-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [ADDR_W:0]     pending_cnt_q, pending_cnt_d;

  logic write_valid, set_valid, set_rise, clr_fall;

  assign write_valid = write_signal && (write_add != '0);
  assign set_valid   = issue_signal && (issue_add != '0);

  // A clear loses to a same-address set: a newer producer has already issued.
  assign set_rise = set_valid && !busy_q[issue_add];
  assign clr_fall = write_signal && busy_q[write_add] && !(set_valid && (issue_add == write_add));

  always_comb begin
    busy_d = busy_q;
    if (write_signal) busy_d[write_add] = 1'b0;
    if (set_valid)    busy_d[issue_add] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pending_cnt_d = pending_cnt_q;
    if (set_rise && !clr_fall) begin
      pending_cnt_d = pending_cnt_q + CNT_ONE;
    end else if (!set_rise && clr_fall) begin
      pending_cnt_d = pending_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      if (write_valid) regs_q[write_add] <= write_data;
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  logic [WORD_LEN-1:0] r1_stored, r2_stored;

  assign r1_stored = (r1_add == '0) ? '0 : regs_q[r1_add];
  assign r2_stored = (r2_add == '0) ? '0 : regs_q[r2_add];

`ifdef RF_BYPASS_EN
  logic r1_fwd, r2_fwd;

  assign r1_fwd = write_valid && (write_add == r1_add);
  assign r2_fwd = write_valid && (write_add == r2_add);

  always_comb begin
    r1      = r1_fwd ? write_data : r1_stored;
    r2      = r2_fwd ? write_data : r2_stored;
    r1_busy = r1_fwd ? (set_valid && (issue_add == r1_add)) : busy_q[r1_add];
    r2_busy = r2_fwd ? (set_valid && (issue_add == r2_add)) : busy_q[r2_add];
  end
`else
  always_comb begin
    r1      = r1_stored;
    r2      = r2_stored;
    r1_busy = busy_q[r1_add];
    r2_busy = busy_q[r2_add];
  end
`endif

  assign stall       = (r1_need && r1_busy) || (r2_need && r2_busy);
  assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb; follows RF_BYPASS_EN if defined.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  r1_add, r2_add;
  logic [31:0] r1, r2;
  logic        write_signal;
  logic [4:0]  write_add;
  logic [31:0] write_data;
  logic        issue_signal;
  logic [4:0]  issue_add;
  logic        r1_need, r2_need;
  logic        r1_busy, r2_busy;
  logic        stall;
  logic [5:0]  pending_cnt;

  int checks   = 0;
  int failures = 0;

  register_file_sb #(
    .WORD_LEN(32),
    .ADDR_W  (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .r1_add      (r1_add),
    .r2_add      (r2_add),
    .r1          (r1),
    .r2          (r2),
    .write_signal(write_signal),
    .write_add   (write_add),
    .write_data  (write_data),
    .issue_signal(issue_signal),
    .issue_add   (issue_add),
    .r1_need     (r1_need),
    .r2_need     (r2_need),
    .r1_busy     (r1_busy),
    .r2_busy     (r2_busy),
    .stall       (stall),
    .pending_cnt (pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst          = 1'b0;
    r1_add       = '0;
    r2_add       = '0;
    write_signal = 1'b0;
    write_add    = '0;
    write_data   = '0;
    issue_signal = 1'b0;
    issue_add    = '0;
    r1_need      = 1'b0;
    r2_need      = 1'b0;
  endtask

  // Advance past the next rising edge, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    write_signal = 1'b1; write_add = 5'd1; write_data = 32'd11;
    issue_signal = 1'b1; issue_add = 5'd4;
    tick();
    write_signal = 1'b1; write_add = 5'd2; write_data = 32'd22;
    tick();
    write_signal = 1'b1; write_add = 5'd3; write_data = 32'd33;
    tick();
    r1_add = 5'd1; r2_add = 5'd4; #1;
    checks++;
    if (r1 !== 32'd11) begin
      failures++; $display("FAIL preload_r1 got=%h exp=%h", r1, 32'd11);
    end
    checks++;
    if (r2_busy !== 1'b1 || pending_cnt !== 6'd1) begin
      failures++; $display("FAIL preload_busy got=%b/%0d exp=1/1", r2_busy, pending_cnt);
    end
    // Reset must override a concurrent write and issue.
    rst = 1'b1;
    write_signal = 1'b1; write_add = 5'd5; write_data = 32'd55;
    issue_signal = 1'b1; issue_add = 5'd6;
    tick();
    for (int a = 1; a <= 6; a++) begin
      r1_add = 5'(a); r2_add = 5'(a); r1_need = 1'b1; r2_need = 1'b1; #1;
      checks++;
      if (r1 !== 32'd0 || r2 !== 32'd0 || r1_busy !== 1'b0 || r2_busy !== 1'b0
          || stall !== 1'b0) begin
        failures++;
        $display("FAIL reset_state a=%0d got r1=%h r2=%h b=%b%b s=%b exp 0/0/00/0",
                 a, r1, r2, r1_busy, r2_busy, stall);
      end
    end
    checks++;
    if (pending_cnt !== 6'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d exp=0", pending_cnt);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    write_signal = 1'b1; write_add = 5'd0; write_data = 32'hDEADBEEF;
    issue_signal = 1'b1; issue_add = 5'd0;
    r1_add = 5'd0; #1;
    checks++;
    if (r1 !== 32'd0 || r1_busy !== 1'b0) begin
      failures++; $display("FAIL zero_same_cycle got=%h/%b exp=0/0", r1, r1_busy);
    end
    tick();
    r1_add = 5'd0; r1_need = 1'b1; #1;
    checks++;
    if (r1 !== 32'd0 || r1_busy !== 1'b0 || stall !== 1'b0 || pending_cnt !== 6'd0) begin
      failures++;
      $display("FAIL zero_reg got=%h/%b/%b/%0d exp=0/0/0/0", r1, r1_busy, stall, pending_cnt);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    issue_signal = 1'b1; issue_add = 5'd5;
    tick();
    r1_add = 5'd5; r1_need = 1'b1; #1;
    checks++;
    if (stall !== 1'b1 || r1_busy !== 1'b1 || pending_cnt !== 6'd1) begin
      failures++; $display("FAIL sb_pending got=%b/%b/%0d exp=1/1/1", stall, r1_busy, pending_cnt);
    end
    r2_add = 5'd5; r2_need = 1'b0; r1_need = 1'b0; #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL sb_no_need got=%b exp=0", stall);
    end
    r1_need = 1'b1;
    write_signal = 1'b1; write_add = 5'd5; write_data = 32'h12345678; #1;
    checks++;
`ifdef RF_BYPASS_EN
    if (stall !== 1'b0 || r1 !== 32'h12345678) begin
      failures++; $display("FAIL sb_wb_same got=%b/%h exp=0/12345678", stall, r1);
    end
`else
    if (stall !== 1'b1 || r1 !== 32'd0) begin
      failures++; $display("FAIL sb_wb_same got=%b/%h exp=1/00000000", stall, r1);
    end
`endif
    tick();
    r1_add = 5'd5; r1_need = 1'b1; #1;
    checks++;
    if (stall !== 1'b0 || r1 !== 32'h12345678 || pending_cnt !== 6'd0) begin
      failures++;
      $display("FAIL sb_wb_after got=%b/%h/%0d exp=0/12345678/0", stall, r1, pending_cnt);
    end
    idle();
  endtask

  task automatic test_bypass();
    write_signal = 1'b1; write_add = 5'd7; write_data = 32'h11111111;
    tick();
    write_signal = 1'b1; write_add = 5'd7; write_data = 32'hA5A5A5A5;
    r2_add = 5'd7; #1;
    checks++;
`ifdef RF_BYPASS_EN
    if (r2 !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL byp_same got=%h exp=a5a5a5a5", r2);
    end
`else
    if (r2 !== 32'h11111111) begin
      failures++; $display("FAIL byp_same got=%h exp=11111111", r2);
    end
`endif
    tick();
    r2_add = 5'd7; #1;
    checks++;
    if (r2 !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL byp_next got=%h exp=a5a5a5a5", r2);
    end
    idle();
  endtask

  task automatic test_simultaneous();
    issue_signal = 1'b1; issue_add = 5'd9;
    tick();
    issue_signal = 1'b1; issue_add = 5'd9;
    write_signal = 1'b1; write_add = 5'd9; write_data = 32'h99;
    r1_add = 5'd9; #1;
    checks++;
    if (r1_busy !== 1'b1) begin
      failures++; $display("FAIL sim_same_busy got=%b exp=1", r1_busy);
    end
    tick();
    r1_add = 5'd9; #1;
    checks++;
    if (r1_busy !== 1'b1 || pending_cnt !== 6'd1) begin
      failures++; $display("FAIL sim_set_wins got=%b/%0d exp=1/1", r1_busy, pending_cnt);
    end
    issue_signal = 1'b1; issue_add = 5'd10;
    write_signal = 1'b1; write_add = 5'd9; write_data = 32'h9A; #1;
    checks++;
`ifdef RF_BYPASS_EN
    if (r1_busy !== 1'b0) begin
      failures++; $display("FAIL sim_diff_same got=%b exp=0", r1_busy);
    end
`else
    if (r1_busy !== 1'b1) begin
      failures++; $display("FAIL sim_diff_same got=%b exp=1", r1_busy);
    end
`endif
    tick();
    r1_add = 5'd9; r2_add = 5'd10; #1;
    checks++;
    if (r1_busy !== 1'b0 || r2_busy !== 1'b1 || pending_cnt !== 6'd1 || r1 !== 32'h9A) begin
      failures++;
      $display("FAIL sim_diff got=%b/%b/%0d/%h exp=0/1/1/9a", r1_busy, r2_busy, pending_cnt, r1);
    end
    write_signal = 1'b1; write_add = 5'd10; write_data = 32'h10;
    tick();
    #1;
    checks++;
    if (pending_cnt !== 6'd0) begin
      failures++; $display("FAIL sim_drain got=%0d exp=0", pending_cnt);
    end
    // Writeback to a non-busy register stores data but leaves the count alone.
    write_signal = 1'b1; write_add = 5'd12; write_data = 32'hCAFE0012;
    tick();
    r1_add = 5'd12; #1;
    checks++;
    if (r1 !== 32'hCAFE0012 || r1_busy !== 1'b0 || pending_cnt !== 6'd0) begin
      failures++;
      $display("FAIL wb_not_busy got=%h/%b/%0d exp=cafe0012/0/0", r1, r1_busy, pending_cnt);
    end
    idle();
  endtask

  task automatic test_fill_drain();
    logic [5:0] exp_cnt;
    for (int a = 1; a <= 31; a++) begin
      issue_signal = 1'b1; issue_add = 5'(a);
      tick();
      exp_cnt = 6'(a); #1;
      checks++;
      if (pending_cnt !== exp_cnt) begin
        failures++; $display("FAIL fill_cnt a=%0d got=%0d exp=%0d", a, pending_cnt, exp_cnt);
      end
    end
    issue_signal = 1'b1; issue_add = 5'd5;
    tick();
    r1_add = 5'd31; r2_add = 5'd1; #1;
    checks++;
    if (pending_cnt !== 6'd31 || r1_busy !== 1'b1 || r2_busy !== 1'b1) begin
      failures++;
      $display("FAIL fill_full got=%0d/%b/%b exp=31/1/1", pending_cnt, r1_busy, r2_busy);
    end
    for (int a = 1; a <= 31; a++) begin
      write_signal = 1'b1; write_add = 5'(a); write_data = 32'(a) * 32'h01010101;
      tick();
      exp_cnt = 6'(31 - a); #1;
      checks++;
      if (pending_cnt !== exp_cnt) begin
        failures++; $display("FAIL drain_cnt a=%0d got=%0d exp=%0d", a, pending_cnt, exp_cnt);
      end
    end
    r1_add = 5'd20; r2_add = 5'd31; r1_need = 1'b1; r2_need = 1'b1; #1;
    checks++;
    if (r1 !== 32'h14141414 || r2 !== 32'h1F1F1F1F || stall !== 1'b0) begin
      failures++; $display("FAIL drain_data got=%h/%h/%b exp=14141414/1f1f1f1f/0", r1, r2, stall);
    end
    idle();
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_zero_reg();
    test_scoreboard();
    test_bypass();
    test_simultaneous();
    test_fill_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised successor to the pipeline register file: two asynchronous read ports, one synchronous write port, and a per-register pending-write scoreboard. Sits in the decode stage. Decode reads operands and marks destinations pending on issue; writeback writes results and clears the pending marks. The block raises a stall request when a needed operand still has an outstanding producer. Register 0 is hardwired to zero and is never pending.

## Interface
- WORD_LEN, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- r1_add, r2_add  in  ADDR_W  read addresses
- r1, r2  out  WORD_LEN  read data
- write_signal  in  1  writeback enable
- write_add  in  ADDR_W  writeback address
- write_data  in  WORD_LEN  writeback data
- issue_signal  in  1  decode issue; marks issue_add pending
- issue_add  in  ADDR_W  destination of the issuing instruction
- r1_need, r2_need  in  1  instruction in decode actually uses r1 / r2
- r1_busy, r2_busy  out  1  addressed register has a pending write
- stall  out  1  (r1_need & r1_busy) | (r2_need & r2_busy)
- pending_cnt  out  ADDR_W+1  number of registers currently pending

## Operation
- Storage: DEPTH x WORD_LEN array and a DEPTH-bit busy vector.
- Write: at the rising edge with write_signal=1 and write_add!=0, regs[write_add] <= write_data. A write to address 0 is discarded; regs[0] always reads 0.
- Read: r1 = regs[r1_add], r2 = regs[r2_add], combinational. Bypass behaviour is described under Configuration.
- Scoreboard set: at the edge with issue_signal=1 and issue_add!=0, busy[issue_add] <= 1.
- Scoreboard clear: at the edge with write_signal=1, busy[write_add] <= 0.
- Simultaneous set and clear of the same address: set wins and the register stays pending, because a newer producer has issued. Set and clear of different addresses both take effect.
- Issue to an already-busy register leaves it busy. Multiple in-flight producers to one register are not tracked.
- Write to a non-busy register still writes the data and leaves the busy bit at 0.
- pending_cnt: a registered counter equal to popcount(busy).
  - Increment when a 0->1 busy transition occurs.
  - Decrement when a 1->0 transition occurs.
  - Both, or neither, leaves it unchanged.
  - It never exceeds DEPTH-1, because address 0 is excluded.
- stall is combinational from the busy outputs and the need inputs. It has no internal state beyond the busy vector.

## Timing
- Reset (rst=1 at an edge): all regs <= 0, busy <= 0, pending_cnt <= 0.
  - Reset overrides any write or issue in the same cycle.
  - Reset mid-operation discards all pending marks.
  - After reset, r1=r2=0, r1_busy=r2_busy=0, stall=0, pending_cnt=0.
- Write latency: data is visible on r1/r2 in the cycle after the write edge. With the bypass enabled it is visible in the same cycle.
- Busy latency: r*_busy rises in the cycle after the issue edge. It falls in the cycle after the writeback edge, or in the same cycle with the bypass enabled.
- Everything is single clock, with no handshake beyond the level-sensitive enables. Inputs are sampled only at the rising edge of clk.

## Configuration
- RF_BYPASS_EN defined:
  - If write_signal=1, write_add!=0 and write_add==rN_add, then rN = write_data combinationally.
  - In that same case rN_busy = 0, unless issue_signal=1 with issue_add==rN_add in the same cycle, in which case rN_busy = 1.
  - stall uses these bypassed busy values.
- RF_BYPASS_EN undefined:
  - rN reflects stored contents only.
  - rN_busy reflects the registered busy bit only.
  - A same-cycle writeback does not lift a stall until the next cycle.

## Test plan
- Reset: load regs 1..3 and issue to 4, then assert rst for one cycle. Required: all reads return 0, r1_busy=r2_busy=0, pending_cnt=0.
- Zero register: write 0xDEADBEEF to address 0 and issue to address 0. Required: r1_add=0 reads 0, r1_busy=0, pending_cnt unchanged.
- Scoreboard: issue to 5, then read r1_add=5 with r1_need=1. Required: stall=1 and pending_cnt=1. Writeback 0x12345678 to 5. Required: stall=0 and r1=0x12345678 in the cycle after, and pending_cnt=0.
- Same-cycle write and read of 7 with 0xA5A5A5A5, r2_add=7. Required: with RF_BYPASS_EN, r2=0xA5A5A5A5 that cycle; without it, the old value that cycle and 0xA5A5A5A5 the next.
- Simultaneous issue and writeback to 9. Required: busy[9] stays 1 and pending_cnt unchanged. Issue 10 with writeback 9. Required: busy[9]=0, busy[10]=1, pending_cnt unchanged.
- Issue addresses 1..31 on consecutive cycles. Required: pending_cnt reaches 31. Then writeback all. Required: pending_cnt returns to 0.
